// File: rtl/clock_pkg.sv
// Shared digit limits, widths and helpers for the time_keeper core.
package clock_pkg;

  localparam int SEC_U_MAX       = 9;
  localparam int SEC_T_MAX       = 5;
  localparam int MIN_U_MAX       = 9;
  localparam int MIN_T_MAX       = 5;
  localparam int HRS_MAX_T       = 2;
  localparam int HRS_MAX_U_AT_T2 = 3;

  localparam int SEC_U_W = 4;
  localparam int SEC_T_W = 3;
  localparam int MIN_U_W = 4;
  localparam int MIN_T_W = 3;
  localparam int HRS_U_W = 4;
  localparam int HRS_T_W = 2;

  // Saturate a set digit to the largest legal value for its position.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Set-digit inputs from the button stage and running-time outputs to the display.
interface time_keeper_if;

  logic       set_mode;
  logic [3:0] set_mu;
  logic [2:0] set_mt;
  logic [3:0] set_hu;
  logic [1:0] set_ht;

  logic [3:0] sec_unit;
  logic [2:0] sec_tens;
  logic [3:0] min_unit;
  logic [2:0] min_tens;
  logic [3:0] hrs_unit;
  logic [1:0] hrs_tens;
  logic       tick_1hz;
  logic       day_wrap;

  modport master (
    output set_mode, set_mu, set_mt, set_hu, set_ht,
    input  sec_unit, sec_tens, min_unit, min_tens, hrs_unit, hrs_tens, tick_1hz, day_wrap
  );

  modport slave (
    input  set_mode, set_mu, set_mt, set_hu, set_ht,
    output sec_unit, sec_tens, min_unit, min_tens, hrs_unit, hrs_tens, tick_1hz, day_wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit with parallel load, increment, and wrap-to-zero carry at MAX.
module bcd_digit #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry
);

  logic [W-1:0] q_d, q_q;

  // Next digit value: load wins over increment.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = (q_q == W'(MAX)) ? '0 : q_q + 1'b1;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && (q_q == W'(MAX));

endmodule

// File: rtl/time_keeper.sv
// 24 h BCD time-of-day core: 1 Hz prescaler, seconds/minutes digit cascade,
// joint hour wrap at 23, and a synchronised set mode that loads HH:MM.
module time_keeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input logic          clk,
  input logic          rst,
  time_keeper_if.slave tk
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          sync1_d, sync1_q;
  logic          set_s_d, set_s_q;
  logic [PW-1:0] pre_d, pre_q;
  logic          tick_d, tick_q;
  logic          wrap_d, wrap_q;
  logic [3:0]    hrs_u_d, hrs_u_q;
  logic [1:0]    hrs_t_d, hrs_t_q;

  logic tick_now;
  logic su_c, st_c, mu_c, mt_c;
  logic set_hrs_bad;
  logic at_23;

  assign tick_now = !set_s_q && (pre_q == PRE_LAST);

  bcd_digit #(.MAX(SEC_U_MAX), .W(SEC_U_W)) u_sec_u (
    .clk(clk), .rst(rst), .inc(tick_now), .load(set_s_q), .load_val('0),
    .q(tk.sec_unit), .carry(su_c));

  bcd_digit #(.MAX(SEC_T_MAX), .W(SEC_T_W)) u_sec_t (
    .clk(clk), .rst(rst), .inc(su_c), .load(set_s_q), .load_val('0),
    .q(tk.sec_tens), .carry(st_c));

  bcd_digit #(.MAX(MIN_U_MAX), .W(MIN_U_W)) u_min_u (
    .clk(clk), .rst(rst), .inc(st_c), .load(set_s_q),
    .load_val(clamp_digit(tk.set_mu, 4'(MIN_U_MAX))),
    .q(tk.min_unit), .carry(mu_c));

  bcd_digit #(.MAX(MIN_T_MAX), .W(MIN_T_W)) u_min_t (
    .clk(clk), .rst(rst), .inc(mu_c), .load(set_s_q),
    .load_val(3'(clamp_digit({1'b0, tk.set_mt}, 4'(MIN_T_MAX)))),
    .q(tk.min_tens), .carry(mt_c));

  // Any hour setting above 23, or a non-BCD unit digit, saturates to 23.
  assign set_hrs_bad = (tk.set_hu > 4'd9) || (tk.set_ht > 2'(HRS_MAX_T)) ||
                       ((tk.set_ht == 2'(HRS_MAX_T)) && (tk.set_hu > 4'(HRS_MAX_U_AT_T2)));
  assign at_23 = (hrs_t_q == 2'(HRS_MAX_T)) && (hrs_u_q == 4'(HRS_MAX_U_AT_T2));

  // Next-state for synchroniser, prescaler, hours and the two pulse outputs.
  always_comb begin
    sync1_d = tk.set_mode;
    set_s_d = sync1_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    hrs_u_d = hrs_u_q;
    hrs_t_d = hrs_t_q;
    if (set_s_q) begin
      pre_d   = '0;
      hrs_t_d = set_hrs_bad ? 2'(HRS_MAX_T)       : tk.set_ht;
      hrs_u_d = set_hrs_bad ? 4'(HRS_MAX_U_AT_T2) : tk.set_hu;
    end else begin
      pre_d  = tick_now ? '0 : pre_q + 1'b1;
      tick_d = tick_now;
      if (mt_c) begin
        if (at_23) begin
          hrs_t_d = '0;
          hrs_u_d = '0;
          wrap_d  = 1'b1;
        end else if (hrs_u_q == 4'd9) begin
          hrs_u_d = '0;
          hrs_t_d = hrs_t_q + 1'b1;
        end else begin
          hrs_u_d = hrs_u_q + 1'b1;
        end
      end
    end
  end

  // Control and hour registers; reset overrides set mode and rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      set_s_q <= 1'b0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      hrs_u_q <= '0;
      hrs_t_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      set_s_q <= set_s_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      hrs_u_q <= hrs_u_d;
      hrs_t_q <= hrs_t_d;
    end
  end

  assign tk.hrs_unit = hrs_u_q;
  assign tk.hrs_tens = hrs_t_q;
  assign tk.tick_1hz = tick_q;
  assign tk.day_wrap = wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: seconds-of-day reference model,
// directed scenarios and randomized set/run/reset traffic.
module tb_time_keeper;

  localparam int TD  = 4;
  localparam int DAY = 86400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_keeper_if tk();

  time_keeper #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .rst(rst),
    .tk (tk)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: time as seconds since midnight plus a cycle counter.
  bit m_sync1 = 0, m_sets = 0, m_old = 0, m_tick = 0, m_wrap = 0;
  int m_pre = 0, m_tod = 0;

  function automatic logic [19:0] pack_tod(input int tod);
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int set_tod(input int ht, input int hu, input int mt, input int mu);
    int h, m;
    h = ht * 10 + hu;
    if (hu > 9 || h > 23) h = 23;
    m = ((mt > 5) ? 5 : mt) * 10 + ((mu > 9) ? 9 : mu);
    return h * 3600 + m * 60;
  endfunction

  function automatic logic [19:0] act_time();
    return {tk.hrs_tens, tk.hrs_unit, tk.min_tens, tk.min_unit, tk.sec_tens, tk.sec_unit};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model step on each rising edge, from the inputs the DUT also samples.
  always @(posedge clk) begin
    if (rst) begin
      m_sync1 = 0; m_sets = 0; m_pre = 0; m_tod = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_old   = m_sets;
      m_sets  = m_sync1;
      m_sync1 = tk.set_mode;
      if (m_old) begin
        m_tod  = set_tod(int'(tk.set_ht), int'(tk.set_hu), int'(tk.set_mt), int'(tk.set_mu));
        m_pre  = 0;
        m_tick = 0;
        m_wrap = 0;
      end else if (m_pre == TD - 1) begin
        m_pre  = 0;
        m_tick = 1;
        m_wrap = (m_tod == DAY - 1);
        m_tod  = (m_tod + 1) % DAY;
      end else begin
        m_pre  = m_pre + 1;
        m_tick = 0;
        m_wrap = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("time", 32'(act_time()), 32'(pack_tod(m_tod)));
      check("tick_1hz", 32'(tk.tick_1hz), 32'(m_tick));
      check("day_wrap", 32'(tk.day_wrap), 32'(m_wrap));
    end
  end

  task automatic run_ticks(input int n, output int wraps);
    int t;
    t = 0;
    wraps = 0;
    for (int c = 0; c < n * TD + 40 && t < n; c++) begin
      @(negedge clk);
      if (tk.tick_1hz) t++;
      if (tk.day_wrap) wraps++;
    end
    if (t != n) check("tick_timeout", 32'(t), 32'(n));
  endtask

  task automatic do_set(input int ht, input int hu, input int mt, input int mu, input int hold);
    tk.set_ht   = 2'(ht);
    tk.set_hu   = 4'(hu);
    tk.set_mt   = 3'(mt);
    tk.set_mu   = 4'(mu);
    tk.set_mode = 1'b1;
    repeat (hold) @(negedge clk);
    tk.set_mode = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wraps, n;
    bit found;
    tk.set_mode = 0; tk.set_mu = 0; tk.set_mt = 0; tk.set_hu = 0; tk.set_ht = 0;
    rst = 1;
    @(posedge clk);
    chk_en = 1;
    repeat (3) @(negedge clk);
    check("reset_time", 32'(act_time()), 32'(0));
    check("reset_tick", 32'(tk.tick_1hz), 32'(0));

    // 1: free run from reset, 40 cycles -> 10 ticks, 00:00:10
    rst = 0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (tk.tick_1hz) n++;
    end
    check("t1_ticks", 32'(n), 32'd10);
    check("t1_time", 32'(act_time()), 32'(pack_tod(10)));
    check("t1_model", 32'(m_tod), 32'd10);

    // 2: 23:59:00 then 60 ticks -> midnight with a single day_wrap
    do_set(2, 3, 5, 9, 6);
    check("t2_loaded", 32'(act_time()), 32'(pack_tod(23 * 3600 + 59 * 60)));
    run_ticks(60, wraps);
    check("t2_time", 32'(act_time()), 32'(0));
    check("t2_wrap_tick", 32'({tk.day_wrap, tk.tick_1hz}), 32'b11);
    check("t2_wraps", 32'(wraps), 32'd1);

    // 3: 19:59:00 + 60 ticks -> 20:00:00, no wrap
    do_set(1, 9, 5, 9, 6);
    run_ticks(60, wraps);
    check("t3_time", 32'(act_time()), 32'(pack_tod(20 * 3600)));
    check("t3_wraps", 32'(wraps), 32'd0);

    // 4: invalid hours saturate, oversize minute unit clamps
    tk.set_ht = 2; tk.set_hu = 7; tk.set_mt = 1; tk.set_mu = 2; tk.set_mode = 1;
    repeat (4) @(negedge clk);
    check("t4_sat", 32'(act_time()), 32'(pack_tod(23 * 3600 + 12 * 60)));
    check("t4_model", 32'(set_tod(2, 7, 1, 2)), 32'(23 * 3600 + 12 * 60));
    tk.set_mu = 4'hC;
    @(negedge clk);
    check("t4_mu_clamp", 32'(tk.min_unit), 32'd9);
    tk.set_mode = 0;
    repeat (4) @(negedge clk);

    // 5: freeze at 00:00:07 and first tick timing after release
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    run_ticks(7, wraps);
    check("t5_time", 32'(act_time()), 32'(pack_tod(7)));
    tk.set_ht = 0; tk.set_hu = 0; tk.set_mt = 0; tk.set_mu = 0; tk.set_mode = 1;
    repeat (3) @(negedge clk);
    check("t5_sec_cleared", 32'({tk.sec_tens, tk.sec_unit}), 32'd0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (tk.tick_1hz) n++;
    end
    check("t5_frozen_ticks", 32'(n), 32'd0);
    tk.set_mode = 0;
    n = 0;
    found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (tk.tick_1hz) begin
        n = c;
        found = 1;
      end
    end
    check("t5_first_tick", 32'(n), 32'(2 + TD));

    // 6: reset lands on the 23:59:59 -> 00:00:00 tick edge
    do_set(2, 3, 5, 9, 6);
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (m_tod == DAY - 1 && m_pre == TD - 1) found = 1;
    end
    check("t6_reached", 32'(found), 32'd1);
    check("t6_pre_time", 32'(act_time()), 32'(pack_tod(DAY - 1)));
    rst = 1;
    @(negedge clk);
    check("t6_time", 32'(act_time()), 32'(0));
    check("t6_wrap", 32'({tk.day_wrap, tk.tick_1hz}), 32'd0);
    rst = 0;

    // Random traffic: set pulses with changing digits, run stretches, resets
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 0;
      end
      n = int'($urandom_range(1, 6));
      tk.set_mode = 1;
      for (int k = 0; k < n; k++) begin
        tk.set_ht = 2'($urandom_range(0, 3));
        tk.set_hu = 4'($urandom_range(0, 15));
        tk.set_mt = 3'($urandom_range(0, 7));
        tk.set_mu = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      tk.set_mode = 0;
      repeat ($urandom_range(0, 90)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
